// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) polynomial reducer: default sizing, FSM states
// and reference polynomials used by benches.
package gf2_pkg;

    localparam int unsigned GF2_W    = 32;
    localparam int unsigned GF2_STEP = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Low coefficients of x^128 + x^7 + x^2 + x + 1 and the IEEE 802.3 CRC-32 generator.
    localparam logic [127:0] GCM_POLY_LO = 128'h87;
    localparam logic [31:0]  CRC32_POLY  = 32'h04C1_1DB7;

endpackage

// File: rtl/gf2_div_step.sv
// Combinational slice of STEP chained MSB-first long-division steps by M = x^W + P.
module gf2_div_step #(
    parameter int unsigned W    = 32,
    parameter int unsigned STEP = 1
) (
    input  logic [2*W-1:0]  r_i,
    input  logic [W-1:0]    p_i,
    output logic [2*W-1:0]  r_o,
    output logic [STEP-1:0] q_o
);

    logic [2*W-1:0] chain [STEP+1];

    assign chain[0] = r_i;

    // The first step's quotient bit lands highest so the shifted Q keeps MSB-first order.
    for (genvar k = 0; k < STEP; k++) begin : g_step
        logic t;
        assign t            = chain[k][2*W-1];
        assign chain[k+1]   = (chain[k] << 1) ^ (t ? {p_i, {W{1'b0}}} : '0);
        assign q_o[STEP-1-k] = t;
    end

    assign r_o = chain[STEP];

endmodule

// File: rtl/gf2_poly_reduce.sv
// Sequential carry-less divider: returns dividend div/mod (x^W + P), STEP quotient
// bits per clock, with valid/ready handshakes on input and output.
module gf2_poly_reduce
    import gf2_pkg::*;
#(
    parameter int unsigned W    = GF2_W,
    parameter int unsigned STEP = GF2_STEP
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   modulus,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    localparam int unsigned CW = $clog2(W + 1);

    state_e            state_q, state_d;
    logic [2*W-1:0]    r_q, r_d, r_step;
    logic [W-1:0]      p_q, p_d;
    logic [W-1:0]      q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [STEP-1:0]   q_step;
    logic [W+STEP-1:0] q_ext;

    gf2_div_step #(
        .W    (W),
        .STEP (STEP)
    ) u_step (
        .r_i (r_q),
        .p_i (p_q),
        .r_o (r_step),
        .q_o (q_step)
    );

    // Concatenate then truncate so STEP == W needs no special-case slice.
    assign q_ext = {q_q, q_step};

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        p_d       = p_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    r_d     = dividend;
                    p_d     = modulus;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(W)) begin
                    state_d = DONE;
                end else begin
                    r_d   = r_step;
                    q_d   = q_ext[W-1:0];
                    cnt_d = cnt_q + CW'(STEP);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q[2*W-1:W];

endmodule
